// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and parity helper for the UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Expected parity bit for a word; unused upper bits must be zero.
    function automatic logic parity_calc(input logic [8:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            2'd1:    p = ^data;
            2'd2:    p = ~(^data);
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop input synchroniser with falling-edge detect, preset high
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    output logic rx_s,
    output logic start_edge
);

    logic meta;
    logic rx_prev;

    // Idle-high line: preset all stages to 1 so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            meta    <= bit_in;
            rx_s    <= meta;
            rx_prev <= rx_s;
        end
    end

    assign start_edge = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output; optional UART_RX_MAJORITY_EN
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_en,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic rx_s;
    logic start_edge;
    logic sample;

    rx_state_t             state;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  perr;
    logic                  ferr;
    logic                  hi_ok;
    logic                  commit_pend;

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Two previous tick samples; the decision tick supplies the third vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else if (tick_en) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    // Frame FSM: counters and bit sampling move only on tick_en; a finished frame raises commit_pend for one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            perr        <= 1'b0;
            ferr        <= 1'b0;
            hi_ok       <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            commit_pend <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (start_edge) begin
                        tick_cnt <= '0;
                        state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick_en) begin
                        if (tick_cnt == TICK_MID) begin
                            if (sample) begin
                                state <= RX_IDLE;
                            end else begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                perr     <= 1'b0;
                                ferr     <= 1'b0;
                                state    <= RX_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (tick_en) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {sample, shreg[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick_en) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            perr     <= parity_calc(9'(shreg), 2'(PARITY)) ^ sample;
                            state    <= RX_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (tick_en) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (!sample) begin
                                ferr <= 1'b1;
                            end
                            if (bit_cnt == STOP_LAST) begin
                                bit_cnt     <= '0;
                                commit_pend <= 1'b1;
                                hi_ok       <= 1'b0;
                                state       <= (ferr || !sample) ? RX_WAIT_IDLE : RX_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                RX_WAIT_IDLE: begin
                    // Leave only after the line has stayed high across a whole tick interval.
                    if (!rx_s) begin
                        hi_ok <= 1'b0;
                    end else if (tick_en) begin
                        if (hi_ok) begin
                            state <= RX_IDLE;
                        end
                        hi_ok <= 1'b1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    // Output word register: commit, overrun drop and consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit_pend) begin
                if (!valid || ready) begin
                    data_out   <= shreg;
                    parity_err <= perr;
                    frame_err  <= ferr;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid      <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - table-driven and scoreboard bench for uart_rx_param (8N1 and 8E1 instances)
module tb_uart_rx_param;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [7:0] d;
        bit         par_en;
        bit         par_bit;
        bit         stop;
        logic       pe;
        logic       fe;
    } vec_t;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_en = 1'b0;
    logic       bit_n = 1'b1;
    logic       bit_e = 1'b1;
    logic       ready_n = 1'b1;
    logic       ready_e = 1'b1;
    logic [7:0] data_n, data_e;
    logic       valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e, ovr_pulse_n, ovr_pulse_e;

    int tests = 0;
    int fails = 0;
    int vcyc_n = 0;
    int ovr_n = 0;
    int tdiv = 0;
    exp_t q_n[$];
    exp_t q_e[$];

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .bit_in(bit_n),
        .data_out(data_n), .valid(valid_n), .ready(ready_n),
        .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_pulse_n)
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .bit_in(bit_e),
        .data_out(data_e), .valid(valid_e), .ready(ready_e),
        .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_pulse_e)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv    <= (tdiv == 3) ? 0 : tdiv + 1;
        tick_en <= (tdiv == 3);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // 8N1 monitor: counts valid cycles and overrun pulses, pops the scoreboard on each accepted word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_n) vcyc_n++;
            if (ovr_pulse_n) ovr_n++;
            if (valid_n && ready_n) begin
                if (q_n.size() == 0) begin
                    check("mon_n_unexpected", {22'd0, data_n, perr_n, ferr_n}, 32'hFFFF_FFFF);
                end else begin
                    e = q_n.pop_front();
                    check("mon_n_word", {22'd0, data_n, perr_n, ferr_n}, {22'd0, e});
                end
            end
        end
    end

    // 8E1 monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_e && ready_e) begin
                if (q_e.size() == 0) begin
                    check("mon_e_unexpected", {22'd0, data_e, perr_e, ferr_e}, 32'hFFFF_FFFF);
                end else begin
                    e = q_e.pop_front();
                    check("mon_e_word", {22'd0, data_e, perr_e, ferr_e}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit sel, input logic v, input int nclk);
        if (sel) bit_e = v;
        else     bit_n = v;
        repeat (nclk) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input bit par_bit, input bit stop);
        drive(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
        if (par_en) drive(sel, par_bit, BIT_CLK);
        drive(sel, stop, BIT_CLK);
        drive(sel, 1'b1, 2 * BIT_CLK);
    endtask

    task automatic wait_empty(input bit sel, input int budget, input string name);
        int n;
        n = 0;
        while (((sel ? q_e.size() : q_n.size()) > 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sel ? q_e.size() : q_n.size(), 0);
    endtask

    initial begin
        vec_t vecs[8];
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h3D, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, data_n}, 32'd0);
        check("rst_flags", {28'd0, valid_n, perr_n, ferr_n, ovr_pulse_n}, 32'd0);
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].sel) q_e.push_back('{vecs[i].d, vecs[i].pe, vecs[i].fe});
            else             q_n.push_back('{vecs[i].d, vecs[i].pe, vecs[i].fe});
            vcyc_n = 0;
            send_frame(vecs[i].sel, vecs[i].d, vecs[i].par_en, vecs[i].par_bit, vecs[i].stop);
            wait_empty(vecs[i].sel, 200, "vec_drain");
            if (i == 0) check("valid_pulse_width", vcyc_n, 1);
        end

        // Short low glitch must be rejected by the start check.
        vcyc_n = 0;
        drive(1'b0, 1'b0, 24);
        drive(1'b0, 1'b1, 2 * BIT_CLK);
        check("glitch_no_valid", vcyc_n, 0);
        check("glitch_state_idle", 32'(dut_n.state), 32'(RX_IDLE));
        q_n.push_back('{8'h55, 1'b0, 1'b0});
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_empty(1'b0, 200, "glitch_follow_drain");

        // Break: stop bit low and line held low for 20 bit times.
        vcyc_n = 0;
        q_n.push_back('{8'h81, 1'b0, 1'b1});
        drive(1'b0, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive(1'b0, (i == 0 || i == 7) ? 1'b1 : 1'b0, BIT_CLK);
        drive(1'b0, 1'b0, 20 * BIT_CLK);
        wait_empty(1'b0, 200, "break_drain");
        check("break_single_word", vcyc_n, 1);
        check("break_wait_idle", 32'(dut_n.state), 32'(RX_WAIT_IDLE));
        drive(1'b0, 1'b1, 2 * BIT_CLK);
        q_n.push_back('{8'h7E, 1'b0, 1'b0});
        send_frame(1'b0, 8'h7E, 1'b0, 1'b0, 1'b1);
        wait_empty(1'b0, 200, "break_follow_drain");

        // Overrun: consumer stalled across two frames.
        ready_n = 1'b0;
        ovr_n = 0;
        q_n.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        check("ovr_held_data", {24'd0, data_n}, 32'h11);
        check("ovr_held_valid", {31'd0, valid_n}, 32'd1);
        check("ovr_pulse_count", ovr_n, 1);
        ready_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("ovr_valid_cleared", {31'd0, valid_n}, 32'd0);
        check("ovr_data_kept", {24'd0, data_n}, 32'h11);
        wait_empty(1'b0, 20, "ovr_drain");

        // Reset in the middle of the data bits of 0xF0.
        drive(1'b0, 1'b0, BIT_CLK);
        drive(1'b0, 1'b0, 3 * BIT_CLK + 32);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, data_n}, 32'd0);
        check("midrst_flags", {28'd0, valid_n, perr_n, ferr_n, ovr_pulse_n}, 32'd0);
        bit_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        q_n.push_back('{8'h0F, 1'b0, 1'b0});
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        wait_empty(1'b0, 200, "midrst_follow_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
